dma_rr_burst_reader: RTL and testbench

Multi-channel successor to the single-shot DMA reader. It arbitrates round-robin between NUM_CHANNELS requesters, then streams a strided burst from a fixed-latency pipelined memory into a shared output buffer. It issues one read per cycle, which removes the dual-edge capture used previously. It sits between the FC layer controllers (weight and input fetch) and the on-chip memory.

---
 rtl/dma_rr_burst_reader.sv | 163 ++++++++++++++++
 tb/tb_dma_rr_burst_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rr_burst_reader.sv
// Round-robin multi-channel DMA reader: grants one requester, streams a strided burst
// from a fixed-latency memory (one read per cycle) into a shared buffer, then pulses done.
module dma_rr_burst_reader #(
   parameter int NUM_CHANNELS      = 2,
   parameter int BUFFER_SIZE       = 20,
   parameter int MEM_ADDRESS_WIDTH = 10,
   parameter int COUNT_WIDTH       = 16,
   parameter int MEM_WIDTH         = 16,
   parameter int MEM_LATENCY       = 1,
   parameter int STRIDE_WIDTH      = 4,
   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_CHANNELS-1:0]                   i_req,
   input  logic [NUM_CHANNELS*MEM_ADDRESS_WIDTH-1:0] i_address,
   input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]       i_count,
   input  logic [NUM_CHANNELS*STRIDE_WIDTH-1:0]      i_stride,
   output logic [NUM_CHANNELS-1:0]                   o_ack,
   output logic                                      o_mem_rd,
   output logic [MEM_ADDRESS_WIDTH-1:0]              o_mem_addr,
   input  logic [MEM_WIDTH-1:0]                      i_mem_data,
   output logic [BUFFER_SIZE*MEM_WIDTH-1:0]          o_buffer,
   output logic                                      o_busy,
   output logic                                      o_done,
   output logic [CH_W-1:0]                           o_done_ch,
   output logic                                      o_clamped
);

   localparam int K_W = $clog2(BUFFER_SIZE + 1);
   localparam int D_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [CH_W-1:0]                rr_q;
   logic [CH_W-1:0]                grant_q;
   logic [MEM_ADDRESS_WIDTH-1:0]   addr_q;
   logic [STRIDE_WIDTH-1:0]        stride_q;
   logic [K_W-1:0]                 n_q;
   logic [K_W-1:0]                 k_q;
   logic [D_W-1:0]                 dcnt_q;
   logic                           clamped_q;
   logic [NUM_CHANNELS-1:0]        ack_q;
   logic [MEM_WIDTH-1:0]           buf_q [BUFFER_SIZE];
   logic                           pv_q  [MEM_LATENCY];
   logic [K_W-1:0]                 pi_q  [MEM_LATENCY];

   logic [CH_W-1:0]                gnt;
   logic                           found;
   logic [CH_W-1:0]                rr_nxt;
   logic [MEM_ADDRESS_WIDTH-1:0]   sel_addr;
   logic [COUNT_WIDTH-1:0]         sel_cnt;
   logic [STRIDE_WIDTH-1:0]        sel_stride;
   logic                           sel_clamp;
   logic [K_W-1:0]                 sel_n;
   logic                           last_word;

   // First requester at or after the round-robin pointer.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (!found && i_req[(int'(rr_q) + i) % NUM_CHANNELS]) begin
            found = 1'b1;
            gnt   = CH_W'((int'(rr_q) + i) % NUM_CHANNELS);
         end
      end
   end

   assign rr_nxt     = (int'(gnt) == NUM_CHANNELS - 1) ? '0 : gnt + CH_W'(1);
   assign sel_addr   = i_address[int'(gnt)*MEM_ADDRESS_WIDTH +: MEM_ADDRESS_WIDTH];
   assign sel_cnt    = i_count[int'(gnt)*COUNT_WIDTH +: COUNT_WIDTH];
   assign sel_stride = i_stride[int'(gnt)*STRIDE_WIDTH +: STRIDE_WIDTH];
   assign sel_clamp  = sel_cnt > COUNT_WIDTH'(BUFFER_SIZE);
   assign sel_n      = sel_clamp ? K_W'(BUFFER_SIZE) : K_W'(sel_cnt);
   assign last_word  = (k_q == n_q - K_W'(1));

   always_comb begin
      state_d    = state_q;
      o_mem_rd   = 1'b0;
      o_mem_addr = '0;
      o_busy     = (state_q != S_IDLE);
      o_done     = 1'b0;
      o_done_ch  = '0;
      o_clamped  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) state_d = (sel_n == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            o_mem_rd   = 1'b1;
            o_mem_addr = addr_q;
            if (last_word) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (dcnt_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            o_done    = 1'b1;
            o_done_ch = grant_q;
            o_clamped = clamped_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_ack = ack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         grant_q   <= '0;
         addr_q    <= '0;
         stride_q  <= '0;
         n_q       <= '0;
         k_q       <= '0;
         dcnt_q    <= '0;
         clamped_q <= 1'b0;
         ack_q     <= '0;
         for (int b = 0; b < BUFFER_SIZE; b++) buf_q[b] <= '0;
         for (int p = 0; p < MEM_LATENCY; p++) begin
            pv_q[p] <= 1'b0;
            pi_q[p] <= '0;
         end
      end else begin
         state_q <= state_d;
         ack_q   <= '0;
         // Outstanding-read tracker: slot MEM_LATENCY-1 marks data present this cycle.
         pv_q[0] <= (state_q == S_ISSUE);
         pi_q[0] <= k_q;
         for (int p = 1; p < MEM_LATENCY; p++) begin
            pv_q[p] <= pv_q[p-1];
            pi_q[p] <= pi_q[p-1];
         end
         if (state_q == S_IDLE && found) begin
            grant_q    <= gnt;
            addr_q     <= sel_addr;
            stride_q   <= sel_stride;
            n_q        <= sel_n;
            k_q        <= '0;
            clamped_q  <= sel_clamp;
            rr_q       <= rr_nxt;
            ack_q[gnt] <= 1'b1;
            for (int b = 0; b < BUFFER_SIZE; b++) buf_q[b] <= '0;
         end else if (state_q == S_ISSUE) begin
            addr_q <= addr_q + MEM_ADDRESS_WIDTH'(stride_q);
            k_q    <= k_q + K_W'(1);
            if (last_word) dcnt_q <= D_W'(MEM_LATENCY - 1);
         end else if (state_q == S_DRAIN && dcnt_q != '0) begin
            dcnt_q <= dcnt_q - D_W'(1);
         end
         if (pv_q[MEM_LATENCY-1]) buf_q[pi_q[MEM_LATENCY-1]] <= i_mem_data;
      end
   end

   for (genvar k = 0; k < BUFFER_SIZE; k++) begin : g_pack
      assign o_buffer[k*MEM_WIDTH +: MEM_WIDTH] = buf_q[k];
   end

endmodule

// File: tb/tb_dma_rr_burst_reader.sv
// Bench for dma_rr_burst_reader: transactions are predicted by an arbitration/burst model
// into a queue; a monitor checks grants, read addresses, timing and buffer contents.
module tb_dma_rr_burst_reader;

   localparam int N  = 2;
   localparam int BS = 20;
   localparam int AW = 10;
   localparam int CW = 16;
   localparam int MW = 16;
   localparam int L  = 3;
   localparam int SW = 4;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      i_req;
   logic [N*AW-1:0]   i_address;
   logic [N*CW-1:0]   i_count;
   logic [N*SW-1:0]   i_stride;
   logic [N-1:0]      o_ack;
   logic              o_mem_rd;
   logic [AW-1:0]     o_mem_addr;
   logic [MW-1:0]     i_mem_data;
   logic [BS*MW-1:0]  o_buffer;
   logic              o_busy;
   logic              o_done;
   logic [0:0]        o_done_ch;
   logic              o_clamped;

   dma_rr_burst_reader #(
      .NUM_CHANNELS(N), .BUFFER_SIZE(BS), .MEM_ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW),
      .MEM_WIDTH(MW), .MEM_LATENCY(L), .STRIDE_WIDTH(SW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_address(i_address), .i_count(i_count),
      .i_stride(i_stride), .o_ack(o_ack), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
      .i_mem_data(i_mem_data), .o_buffer(o_buffer), .o_busy(o_busy), .o_done(o_done),
      .o_done_ch(o_done_ch), .o_clamped(o_clamped)
   );

   typedef struct {
      int ch;
      int addr;
      int cnt;
      int stride;
      bit b2b;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   int   m_rr   = 0;
   int   ch_addr [N];
   int   ch_cnt  [N];
   int   ch_str  [N];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic int mem_val(input int a);
      return (a + 'h100) & 'hFFFF;
   endfunction

   // Memory: data for a read issued in cycle t is presented during cycle t+L, garbage otherwise.
   logic          hist_rd [L];
   logic [AW-1:0] hist_a  [L];
   initial begin
      for (int j = 0; j < L; j++) begin
         hist_rd[j] = 1'b0;
         hist_a[j]  = '0;
      end
      forever begin
         @(negedge clk);
         for (int j = L - 1; j > 0; j--) begin
            hist_rd[j] = hist_rd[j-1];
            hist_a[j]  = hist_a[j-1];
         end
         hist_rd[0] = o_mem_rd;
         hist_a[0]  = o_mem_addr;
      end
   end

   initial begin
      i_mem_data = '0;
      forever begin
         @(posedge clk);
         #1;
         i_mem_data = hist_rd[L-1] ? MW'(mem_val(int'(hist_a[L-1]))) : MW'($urandom);
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit   active;
      int   ack_cyc;
      int   last_done;
      int   got[$];
      int   n;
      exp_t e;
      active    = 1'b0;
      ack_cyc   = 0;
      last_done = -100;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            got.delete();
            continue;
         end
         if (o_ack != '0) begin
            if (exp_q.size() == 0) chk("unexpected_ack", longint'(o_ack), 0);
            else begin
               chk("ack_channel", longint'(o_ack), longint'(1) << exp_q[0].ch);
               if (exp_q[0].b2b) chk("pending_grant_cycle", cyc, last_done + 2);
            end
            active  = 1'b1;
            ack_cyc = cyc;
            got.delete();
         end
         if (o_mem_rd) begin
            if (active) got.push_back(int'(o_mem_addr));
            else chk("stray_read", 1, 0);
         end
         chk("busy", longint'(o_busy), longint'(active));
         if (o_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               n = (e.cnt > BS) ? BS : e.cnt;
               chk("done_ch", longint'(o_done_ch), e.ch);
               chk("clamped", longint'(o_clamped), longint'(e.cnt > BS));
               chk("done_latency", cyc - ack_cyc, (n == 0) ? 0 : n + L);
               chk("read_count", got.size(), n);
               for (int k = 0; k < n && k < got.size(); k++)
                  chk("read_addr", got[k], (e.addr + k * e.stride) % (1 << AW));
               for (int k = 0; k < BS; k++)
                  chk("buffer", longint'(o_buffer[k*MW +: MW]),
                      (k < n) ? mem_val((e.addr + k * e.stride) % (1 << AW)) : 0);
            end
            active    = 1'b0;
            last_done = cyc;
         end
      end
   end

   task automatic drive_params();
      for (int c = 0; c < N; c++) begin
         i_address[c*AW +: AW] = AW'(ch_addr[c]);
         i_count[c*CW +: CW]   = CW'(ch_cnt[c]);
         i_stride[c*SW +: SW]  = SW'(ch_str[c]);
      end
   endtask

   // Predict grant order from the model pointer, raise requests, drop each on its ack.
   task automatic launch(input logic [N-1:0] mask);
      logic [N-1:0] rem;
      bit           first;
      int           c;
      int           budget;
      exp_t         e;
      rem   = mask;
      first = 1'b1;
      while (rem != '0) begin
         for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (rem[c]) begin
               e.ch = c; e.addr = ch_addr[c]; e.cnt = ch_cnt[c]; e.stride = ch_str[c];
               e.b2b = !first;
               exp_q.push_back(e);
               rem[c] = 1'b0;
               m_rr   = (c + 1) % N;
               first  = 1'b0;
               break;
            end
         end
      end
      @(negedge clk);
      drive_params();
      i_req  = mask;
      budget = 0;
      while ((i_req != '0 || exp_q.size() != 0) && budget < 400) begin
         @(negedge clk);
         #1;
         i_req = i_req & ~o_ack;
         budget++;
      end
      chk("transfers_complete", exp_q.size(), 0);
      exp_q.delete();
      i_req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_ch(input int c, input int a, input int n, input int s);
      ch_addr[c] = a;
      ch_cnt[c]  = n;
      ch_str[c]  = s;
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_ack"},     longint'(o_ack), 0);
      chk({pfx, "_mem_rd"},  longint'(o_mem_rd), 0);
      chk({pfx, "_mem_addr"},longint'(o_mem_addr), 0);
      chk({pfx, "_busy"},    longint'(o_busy), 0);
      chk({pfx, "_done"},    longint'(o_done), 0);
      chk({pfx, "_done_ch"}, longint'(o_done_ch), 0);
      chk({pfx, "_clamped"}, longint'(o_clamped), 0);
      chk({pfx, "_buffer_zero"}, longint'(o_buffer == '0), 1);
   endtask

   initial begin
      int   budget;
      exp_t e;
      rst_n = 1'b1;
      i_req = '0;
      i_address = '0;
      i_count = '0;
      i_stride = '0;
      for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0);
      #1 rst_n = 1'b0;
      #2 chk_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      set_ch(0, 'h010, 4, 1);
      launch(2'b01);
      set_ch(1, 'h3FE, 3, 2);
      launch(2'b10);
      set_ch(0, 'h100, 25, 3);
      launch(2'b01);
      set_ch(1, 'h055, 0, 1);
      launch(2'b10);
      set_ch(0, 'h2A0, 5, 0);
      set_ch(1, 'h040, 6, 7);
      launch(2'b11);
      launch(2'b11);

      // Reset during the third issue word of an 8-word burst.
      set_ch(0, 'h200, 8, 5);
      e.ch = 0; e.addr = 'h200; e.cnt = 8; e.stride = 5; e.b2b = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      drive_params();
      i_req  = 2'b01;
      budget = 0;
      while (o_ack[0] !== 1'b1 && budget < 50) begin
         @(negedge clk);
         #1;
         budget++;
      end
      chk("abort_ack_seen", longint'(o_ack[0]), 1);
      i_req = '0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("abort");
      exp_q.delete();
      m_rr = 0;
      repeat (3) @(negedge clk);
      chk("abort_no_done", longint'(o_done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      set_ch(0, 'h123, 3, 4);
      set_ch(1, 'h3F0, 4, 9);
      launch(2'b11);

      for (int it = 0; it < 14; it++) begin
         for (int c = 0; c < N; c++)
            set_ch(c, int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, 25)),
                   int'($urandom_range(0, (1 << SW) - 1)));
         launch(N'($urandom_range(1, (1 << N) - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
